// File: rtl/acc_arb_pkg.sv
// Shared types and width helpers for the accelerator request arbiter.
package acc_arb_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Width of an index into num_idx entries; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned num_idx);
      return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
   endfunction

   function automatic int unsigned ext_id_width(input int unsigned id_w,
                                                input int unsigned num_req);
      return id_w + idx_width(num_req);
   endfunction

endpackage

// File: rtl/acc_rr_sel.sv
// Combinational round-robin select: first eligible index at or after rr_ptr_i, with wrap.
module acc_rr_sel import acc_arb_pkg::*; #(
   parameter  int unsigned NumReq   = 4,
   localparam int unsigned IdxWidth = idx_width(NumReq)
) (
   input  logic [NumReq-1:0]   eligible_i,
   input  logic [IdxWidth-1:0] rr_ptr_i,
   output logic [IdxWidth-1:0] gnt_idx_o,
   output logic                gnt_valid_o
);

   always_comb begin
      logic [IdxWidth-1:0] cand;
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      cand        = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         cand = IdxWidth'((32'(rr_ptr_i) + k) % NumReq);
         if (!gnt_valid_o && eligible_i[cand]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/acc_req_arbiter.sv
// Round-robin arbiter sharing one accelerator request/response port among NumReq requesters,
// with ID extension, response routing, per-requester outstanding limits and a sticky error.
module acc_req_arbiter import acc_arb_pkg::*; #(
   parameter  int unsigned NumReq         = 4,
   parameter  int unsigned DataWidth      = 32,
   parameter  int unsigned AddrWidth      = 4,
   parameter  int unsigned IdWidth        = 5,
   parameter  int unsigned MaxOutstanding = 4,
   localparam int unsigned IdxWidth       = idx_width(NumReq)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NumReq-1:0]                    slv_req_valid_i,
   output logic [NumReq-1:0]                    slv_req_ready_o,
   input  logic [NumReq-1:0][AddrWidth-1:0]     slv_req_addr_i,
   input  logic [NumReq-1:0][DataWidth-1:0]     slv_req_data_i,
   input  logic [NumReq-1:0][IdWidth-1:0]       slv_req_id_i,
   output logic [NumReq-1:0]                    slv_rsp_valid_o,
   input  logic [NumReq-1:0]                    slv_rsp_ready_i,
   output logic [DataWidth-1:0]                 slv_rsp_data_o,
   output logic [IdWidth-1:0]                   slv_rsp_id_o,
   output logic                                 mst_req_valid_o,
   input  logic                                 mst_req_ready_i,
   output logic [AddrWidth-1:0]                 mst_req_addr_o,
   output logic [DataWidth-1:0]                 mst_req_data_o,
   output logic [IdWidth+IdxWidth-1:0]          mst_req_id_o,
   input  logic                                 mst_rsp_valid_i,
   output logic                                 mst_rsp_ready_o,
   input  logic [DataWidth-1:0]                 mst_rsp_data_i,
   input  logic [IdWidth+IdxWidth-1:0]          mst_rsp_id_i,
   output logic                                 err_o
);

   localparam int unsigned         CntWidth   = $clog2(MaxOutstanding + 1);
   localparam int unsigned         ExtIdWidth = ext_id_width(IdWidth, NumReq);
   localparam logic [CntWidth-1:0] CntMax     = CntWidth'(MaxOutstanding);

   arb_state_e                      state_q, state_d;
   logic [IdxWidth-1:0]             rr_ptr_q, rr_ptr_d;
   logic [IdxWidth-1:0]             lock_idx_q, lock_idx_d;
   logic [NumReq-1:0][CntWidth-1:0] cnt_q, cnt_d;
   logic                            err_q, err_d;

   logic [NumReq-1:0]   eligible;
   logic [IdxWidth-1:0] rr_gnt_idx, sel_idx, rsp_idx;
   logic                rr_gnt_valid, lock_valid, sel_valid, req_hs;
   logic                rsp_known, rsp_cnt_zero, rsp_ready, rsp_bad, rsp_hs;

   function automatic logic [IdxWidth-1:0] wrap_inc(input logic [IdxWidth-1:0] idx);
      return (32'(idx) == NumReq - 1) ? '0 : idx + 1'b1;
   endfunction

   always_comb begin
      for (int unsigned i = 0; i < NumReq; i++) begin
         eligible[i] = slv_req_valid_i[i] && (cnt_q[i] < CntMax);
      end
   end

   acc_rr_sel #(
      .NumReq (NumReq)
   ) i_rr_sel (
      .eligible_i  (eligible),
      .rr_ptr_i    (rr_ptr_q),
      .gnt_idx_o   (rr_gnt_idx),
      .gnt_valid_o (rr_gnt_valid)
   );

   // A locked grant ignores the counter so the presented beat cannot change under backpressure.
   assign lock_valid = slv_req_valid_i[lock_idx_q];
   assign sel_idx    = (state_q == LOCKED) ? lock_idx_q : rr_gnt_idx;
   assign sel_valid  = rst_ni && ((state_q == LOCKED) ? lock_valid : rr_gnt_valid);
   assign req_hs     = sel_valid && mst_req_ready_i;

   assign mst_req_valid_o = sel_valid;
   assign mst_req_addr_o  = slv_req_addr_i[sel_idx];
   assign mst_req_data_o  = slv_req_data_i[sel_idx];
   assign mst_req_id_o    = {sel_idx, slv_req_id_i[sel_idx]};

   always_comb begin
      slv_req_ready_o = '0;
      if (sel_valid) begin
         slv_req_ready_o[sel_idx] = mst_req_ready_i;
      end
   end

   assign rsp_idx        = mst_rsp_id_i[ExtIdWidth-1:IdWidth];
   assign slv_rsp_id_o   = mst_rsp_id_i[IdWidth-1:0];
   assign slv_rsp_data_o = mst_rsp_data_i;

   always_comb begin
      rsp_known    = 1'b0;
      rsp_cnt_zero = 1'b0;
      rsp_ready    = 1'b0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         if (32'(rsp_idx) == i) begin
            rsp_known    = 1'b1;
            rsp_cnt_zero = (cnt_q[i] == '0);
            rsp_ready    = slv_rsp_ready_i[i];
         end
      end
   end

   // Unroutable or unexpected responses are swallowed so the shared port never stalls on them.
   assign rsp_bad         = !rsp_known || rsp_cnt_zero;
   assign rsp_hs          = rst_ni && mst_rsp_valid_i && !rsp_bad && rsp_ready;
   assign mst_rsp_ready_o = rst_ni && (rsp_bad || rsp_ready);

   always_comb begin
      slv_rsp_valid_o = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         slv_rsp_valid_o[i] = rst_ni && mst_rsp_valid_i && !rsp_bad && (32'(rsp_idx) == i);
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      lock_idx_d = lock_idx_q;
      err_d      = err_q;
      if (mst_rsp_valid_i && rsp_bad) begin
         err_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (rr_gnt_valid) begin
               if (mst_req_ready_i) begin
                  rr_ptr_d = wrap_inc(rr_gnt_idx);
               end else begin
                  lock_idx_d = rr_gnt_idx;
                  state_d    = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (!lock_valid) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (mst_req_ready_i) begin
               rr_ptr_d = wrap_inc(lock_idx_q);
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      logic inc, dec;
      cnt_d = cnt_q;
      inc   = 1'b0;
      dec   = 1'b0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         inc = req_hs && (32'(sel_idx) == i) && (cnt_q[i] != CntMax);
         dec = rsp_hs && (32'(rsp_idx) == i);
         if (inc && !dec) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end else if (dec && !inc) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         lock_idx_q <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_idx_q <= lock_idx_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_acc_req_arbiter.sv
// Directed bench for acc_req_arbiter with a cycle-level reference model and literal checks.
module tb_acc_req_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int IW = 5;
   localparam int MO = 4;
   localparam int XW = IW + 2;

   logic                   clk = 1'b0;
   logic                   rst_ni = 1'b0;
   logic [N-1:0]           slv_req_valid_i;
   logic [N-1:0]           slv_req_ready_o;
   logic [N-1:0][AW-1:0]   slv_req_addr_i;
   logic [N-1:0][DW-1:0]   slv_req_data_i;
   logic [N-1:0][IW-1:0]   slv_req_id_i;
   logic [N-1:0]           slv_rsp_valid_o;
   logic [N-1:0]           slv_rsp_ready_i;
   logic [DW-1:0]          slv_rsp_data_o;
   logic [IW-1:0]          slv_rsp_id_o;
   logic                   mst_req_valid_o;
   logic                   mst_req_ready_i;
   logic [AW-1:0]          mst_req_addr_o;
   logic [DW-1:0]          mst_req_data_o;
   logic [XW-1:0]          mst_req_id_o;
   logic                   mst_rsp_valid_i;
   logic                   mst_rsp_ready_o;
   logic [DW-1:0]          mst_rsp_data_i;
   logic [XW-1:0]          mst_rsp_id_i;
   logic                   err_o;

   acc_req_arbiter #(
      .NumReq         (N),
      .DataWidth      (DW),
      .AddrWidth      (AW),
      .IdWidth        (IW),
      .MaxOutstanding (MO)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .slv_req_valid_i (slv_req_valid_i),
      .slv_req_ready_o (slv_req_ready_o),
      .slv_req_addr_i  (slv_req_addr_i),
      .slv_req_data_i  (slv_req_data_i),
      .slv_req_id_i    (slv_req_id_i),
      .slv_rsp_valid_o (slv_rsp_valid_o),
      .slv_rsp_ready_i (slv_rsp_ready_i),
      .slv_rsp_data_o  (slv_rsp_data_o),
      .slv_rsp_id_o    (slv_rsp_id_o),
      .mst_req_valid_o (mst_req_valid_o),
      .mst_req_ready_i (mst_req_ready_i),
      .mst_req_addr_o  (mst_req_addr_o),
      .mst_req_data_o  (mst_req_data_o),
      .mst_req_id_o    (mst_req_id_o),
      .mst_rsp_valid_i (mst_rsp_valid_i),
      .mst_rsp_ready_o (mst_rsp_ready_o),
      .mst_rsp_data_i  (mst_rsp_data_i),
      .mst_rsp_id_i    (mst_rsp_id_i),
      .err_o           (err_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int dut_grants[N];

   // Reference model state: counters, pointer, lock and sticky error as plain integers.
   int m_cnt[N];
   int m_ptr    = 0;
   bit m_locked = 1'b0;
   int m_lock   = 0;
   bit m_err    = 1'b0;
   int m_g      = -1;
   int m_r      = 0;
   bit m_bad    = 1'b1;

   logic [N-1:0]  e_req_ready, e_rsp_valid;
   logic          e_mvalid, e_mrsp_ready;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data;
   logic [XW-1:0] e_id;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_eval();
      int c;
      e_req_ready  = '0;
      e_rsp_valid  = '0;
      e_mvalid     = 1'b0;
      e_mrsp_ready = 1'b0;
      e_addr       = '0;
      e_data       = '0;
      e_id         = '0;
      m_g          = -1;
      m_r          = int'(mst_rsp_id_i[XW-1:IW]);
      m_bad        = 1'b1;
      if (rst_ni) begin
         if (m_locked) begin
            if (slv_req_valid_i[m_lock]) m_g = m_lock;
         end else begin
            for (int k = 0; k < N; k++) begin
               c = (m_ptr + k) % N;
               if (m_g < 0 && slv_req_valid_i[c] && m_cnt[c] < MO) m_g = c;
            end
         end
         if (m_g >= 0) begin
            e_mvalid         = 1'b1;
            e_addr           = slv_req_addr_i[m_g];
            e_data           = slv_req_data_i[m_g];
            e_id             = {2'(m_g), slv_req_id_i[m_g]};
            e_req_ready[m_g] = mst_req_ready_i;
         end
         m_bad = (m_r >= N) || (m_cnt[m_r] == 0);
         if (m_bad) begin
            e_mrsp_ready = 1'b1;
         end else begin
            e_rsp_valid[m_r] = mst_rsp_valid_i;
            e_mrsp_ready     = slv_rsp_ready_i[m_r];
         end
      end
   endtask

   task automatic model_commit();
      if (!rst_ni) begin
         m_ptr    = 0;
         m_locked = 1'b0;
         m_lock   = 0;
         m_err    = 1'b0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
      end else begin
         if (mst_rsp_valid_i && m_bad) m_err = 1'b1;
         if (m_locked && m_g < 0) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
         end else if (m_g >= 0) begin
            if (mst_req_ready_i) begin
               m_ptr    = (m_g + 1) % N;
               m_locked = 1'b0;
               m_cnt[m_g]++;
            end else begin
               m_locked = 1'b1;
               m_lock   = m_g;
            end
         end
         if (mst_rsp_valid_i && !m_bad && slv_rsp_ready_i[m_r]) m_cnt[m_r]--;
      end
   endtask

   // Compare process: one cycle per iteration, sampled 1 time unit before the rising edge.
   initial begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      foreach (dut_grants[i]) dut_grants[i] = 0;
      forever begin
         @(negedge clk);
         #4;
         model_eval();
         chk("mst_req_valid", 64'(mst_req_valid_o), 64'(e_mvalid));
         chk("slv_req_ready", 64'(slv_req_ready_o), 64'(e_req_ready));
         chk("slv_rsp_valid", 64'(slv_rsp_valid_o), 64'(e_rsp_valid));
         chk("mst_rsp_ready", 64'(mst_rsp_ready_o), 64'(e_mrsp_ready));
         chk("err", 64'(err_o), 64'(m_err));
         if (e_mvalid) begin
            chk("mst_req_addr", 64'(mst_req_addr_o), 64'(e_addr));
            chk("mst_req_data", 64'(mst_req_data_o), 64'(e_data));
            chk("mst_req_id", 64'(mst_req_id_o), 64'(e_id));
         end
         if (|e_rsp_valid) begin
            chk("slv_rsp_data", 64'(slv_rsp_data_o), 64'(mst_rsp_data_i));
            chk("slv_rsp_id", 64'(slv_rsp_id_o), 64'(mst_rsp_id_i[IW-1:0]));
         end
         if (rst_ni && mst_req_valid_o === 1'b1 && mst_req_ready_i)
            dut_grants[mst_req_id_o[XW-1:IW]]++;
         model_commit();
      end
   end

   task automatic clr();
      slv_req_valid_i = '0;
      slv_req_addr_i  = '0;
      slv_req_data_i  = '0;
      slv_req_id_i    = '0;
      slv_rsp_ready_i = '0;
      mst_req_ready_i = 1'b0;
      mst_rsp_valid_i = 1'b0;
      mst_rsp_data_i  = '0;
      mst_rsp_id_i    = '0;
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic rsp_to(input int idx);
      nxt();
      clr();
      mst_rsp_valid_i = 1'b1;
      mst_rsp_id_i    = {2'(idx), 5'd0};
      slv_rsp_ready_i = '1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      nxt();
      rst_ni = 1'b1;
   endtask

   initial begin
      // Reset: outputs forced low even with every input asserted.
      clr();
      slv_req_valid_i = '1;
      mst_req_ready_i = 1'b1;
      mst_rsp_valid_i = 1'b1;
      slv_rsp_ready_i = '1;
      nxt();
      nxt();
      #2;
      chk("rst_mst_req_valid", 64'(mst_req_valid_o), 64'd0);
      chk("rst_slv_req_ready", 64'(slv_req_ready_o), 64'd0);
      chk("rst_slv_rsp_valid", 64'(slv_rsp_valid_o), 64'd0);
      chk("rst_mst_rsp_ready", 64'(mst_rsp_ready_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      nxt();
      clr();
      rst_ni = 1'b1;

      // Single requester 2, id 5: zero-latency grant and routed response.
      nxt();
      slv_req_valid_i   = 4'b0100;
      slv_req_id_i[2]   = 5'd5;
      slv_req_addr_i[2] = 4'hA;
      slv_req_data_i[2] = 32'hDEAD_0002;
      mst_req_ready_i   = 1'b1;
      #2;
      chk("t1_req_valid", 64'(mst_req_valid_o), 64'd1);
      chk("t1_req_id", 64'(mst_req_id_o), 64'h45);
      chk("t1_req_ready", 64'(slv_req_ready_o), 64'b0100);
      chk("t1_req_data", 64'(mst_req_data_o), 64'hDEAD_0002);
      nxt();
      clr();
      chk("t1_model_cnt2", 64'(m_cnt[2]), 64'd1);
      mst_rsp_valid_i = 1'b1;
      mst_rsp_id_i    = 7'h45;
      mst_rsp_data_i  = 32'h0BAD_F00D;
      slv_rsp_ready_i = 4'b0100;
      #2;
      chk("t1_rsp_valid", 64'(slv_rsp_valid_o), 64'b0100);
      chk("t1_rsp_id", 64'(slv_rsp_id_o), 64'd5);
      chk("t1_rsp_data", 64'(slv_rsp_data_o), 64'h0BAD_F00D);
      chk("t1_mst_rsp_ready", 64'(mst_rsp_ready_o), 64'd1);
      nxt();
      clr();
      chk("t1_model_cnt2_after", 64'(m_cnt[2]), 64'd0);
      #2;
      chk("t1_no_err", 64'(err_o), 64'd0);

      // Fairness: all four requesters always valid, each grant answered one cycle later.
      do_reset();
      foreach (dut_grants[i]) dut_grants[i] = 0;
      for (int k = 0; k < 100; k++) begin
         nxt();
         slv_req_valid_i = '1;
         mst_req_ready_i = 1'b1;
         slv_rsp_ready_i = '1;
         for (int i = 0; i < N; i++) slv_req_id_i[i] = IW'(i);
         mst_rsp_valid_i = (k > 0);
         mst_rsp_id_i    = {2'((k + 3) % 4), IW'((k + 3) % 4)};
         #2;
         chk("fair_order", 64'(mst_req_id_o[XW-1:IW]), 64'(k % 4));
      end
      nxt();
      clr();
      mst_rsp_valid_i = 1'b1;
      mst_rsp_id_i    = {2'd3, 5'd3};
      slv_rsp_ready_i = 4'b1000;
      nxt();
      clr();
      for (int i = 0; i < N; i++) chk("fair_count", 64'(dut_grants[i]), 64'd25);

      // Backpressure lock on requester 1 while requester 0 competes.
      nxt();
      slv_req_valid_i   = 4'b0010;
      slv_req_id_i[1]   = 5'd9;
      slv_req_data_i[1] = 32'h1111_0001;
      mst_req_ready_i   = 1'b0;
      #2;
      chk("lock_gnt_first", 64'(mst_req_id_o[XW-1:IW]), 64'd1);
      for (int k = 0; k < 2; k++) begin
         nxt();
         slv_req_valid_i   = 4'b0011;
         slv_req_data_i[0] = 32'h0000_AAAA;
         #2;
         chk("lock_gnt_held", 64'(mst_req_id_o[XW-1:IW]), 64'd1);
         chk("lock_data_stable", 64'(mst_req_data_o), 64'h1111_0001);
         chk("lock_no_ready", 64'(slv_req_ready_o), 64'd0);
      end
      nxt();
      slv_req_valid_i = 4'b1111;
      mst_req_ready_i = 1'b1;
      #2;
      chk("lock_release", 64'(slv_req_ready_o), 64'b0010);
      nxt();
      slv_req_valid_i = 4'b1101;
      #2;
      chk("post_lock_gnt2", 64'(mst_req_id_o[XW-1:IW]), 64'd2);
      nxt();
      slv_req_valid_i = 4'b1001;
      #2;
      chk("post_lock_gnt3", 64'(mst_req_id_o[XW-1:IW]), 64'd3);
      nxt();
      slv_req_valid_i = 4'b0001;
      #2;
      chk("post_lock_gnt0", 64'(mst_req_id_o[XW-1:IW]), 64'd0);
      for (int i = 0; i < N; i++) rsp_to(i);
      nxt();
      clr();

      // Outstanding limit on requester 0.
      for (int k = 0; k < MO; k++) begin
         nxt();
         clr();
         slv_req_valid_i = 4'b0001;
         mst_req_ready_i = 1'b1;
         #2;
         chk("os_grant", 64'(slv_req_ready_o), 64'b0001);
      end
      nxt();
      slv_req_valid_i = 4'b0011;
      #2;
      chk("os_model_cnt0", 64'(m_cnt[0]), 64'd4);
      chk("os_full_ready", 64'(slv_req_ready_o), 64'b0010);
      chk("os_full_gnt", 64'(mst_req_id_o[XW-1:IW]), 64'd1);
      nxt();
      slv_req_valid_i = 4'b0001;
      mst_rsp_valid_i = 1'b1;
      mst_rsp_id_i    = {2'd0, 5'd0};
      slv_rsp_ready_i = 4'b0001;
      #2;
      chk("os_blocked", 64'(slv_req_ready_o), 64'd0);
      nxt();
      mst_rsp_valid_i = 1'b0;
      slv_rsp_ready_i = '0;
      #2;
      chk("os_resume", 64'(slv_req_ready_o), 64'b0001);
      rsp_to(1);
      for (int k = 0; k < MO; k++) rsp_to(0);
      nxt();
      clr();

      // Simultaneous request and response handshakes on requester 3.
      nxt();
      slv_req_valid_i = 4'b1000;
      mst_req_ready_i = 1'b1;
      nxt();
      mst_rsp_valid_i = 1'b1;
      mst_rsp_id_i    = {2'd3, 5'd7};
      slv_rsp_ready_i = 4'b1000;
      #2;
      chk("sim_req_ready", 64'(slv_req_ready_o), 64'b1000);
      chk("sim_rsp_valid", 64'(slv_rsp_valid_o), 64'b1000);
      nxt();
      clr();
      chk("sim_model_cnt3", 64'(m_cnt[3]), 64'd1);
      rsp_to(3);
      #2;
      chk("sim_rsp_after", 64'(slv_rsp_valid_o), 64'b1000);
      nxt();
      clr();
      #2;
      chk("sim_no_err", 64'(err_o), 64'd0);

      // Response to a requester with nothing outstanding is sunk and flagged.
      nxt();
      mst_rsp_valid_i = 1'b1;
      mst_rsp_id_i    = {2'd3, 5'd1};
      slv_rsp_ready_i = '0;
      #2;
      chk("err_sink_ready", 64'(mst_rsp_ready_o), 64'd1);
      chk("err_sink_valid", 64'(slv_rsp_valid_o), 64'd0);
      nxt();
      clr();
      #2;
      chk("err_set", 64'(err_o), 64'd1);
      nxt();
      #2;
      chk("err_sticky", 64'(err_o), 64'd1);
      do_reset();
      #2;
      chk("err_reset", 64'(err_o), 64'd0);

      // Valid dropped while locked.
      nxt();
      slv_req_valid_i = 4'b0100;
      mst_req_ready_i = 1'b0;
      nxt();
      slv_req_valid_i = '0;
      nxt();
      #2;
      chk("drop_err", 64'(err_o), 64'd1);
      do_reset();

      // Response to a transaction issued before a reset.
      nxt();
      slv_req_valid_i = 4'b0010;
      mst_req_ready_i = 1'b1;
      nxt();
      clr();
      do_reset();
      mst_rsp_valid_i = 1'b1;
      mst_rsp_id_i    = {2'd1, 5'd0};
      slv_rsp_ready_i = '1;
      #2;
      chk("stale_rsp_sunk", 64'(slv_rsp_valid_o), 64'd0);
      nxt();
      clr();
      #2;
      chk("stale_err", 64'(err_o), 64'd1);
      nxt();
      nxt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
